// File: rtl/operation_sequencer_pkg.sv
// Shared definitions for the operation sequencer: operation codes,
// instruction opcodes, FSM state encodings and small decode helpers.
package operation_sequencer_pkg;

  localparam int OPERATION_CODE_LENGTH = 4;
  localparam int SEQ_OPCODE_W = 4;

  typedef logic [OPERATION_CODE_LENGTH-1:0] operT;

  localparam operT OPER_RESET              = 4'd0;
  localparam operT OPER_HALT               = 4'd1;
  localparam operT OPER_READ_INST          = 4'd2;
  localparam operT OPER_READ_REGS          = 4'd3;
  localparam operT OPER_ENABLE_ALU_AND_RUN = 4'd4;
  localparam operT OPER_READ_MEM           = 4'd5;
  localparam operT OPER_WRITE_REG          = 4'd6;
  localparam operT OPER_WRITE_MEM          = 4'd7;
  localparam operT OPER_PUSH_TO_STACK      = 4'd8;
  localparam operT OPER_POP_FROM_STACK     = 4'd9;
  localparam operT OPER_SET_PC             = 4'd10;

  localparam logic [SEQ_OPCODE_W-1:0] OPC_NOP   = 4'd0;
  localparam logic [SEQ_OPCODE_W-1:0] OPC_ALU   = 4'd1;
  localparam logic [SEQ_OPCODE_W-1:0] OPC_LOAD  = 4'd2;
  localparam logic [SEQ_OPCODE_W-1:0] OPC_STORE = 4'd3;
  localparam logic [SEQ_OPCODE_W-1:0] OPC_PUSH  = 4'd4;
  localparam logic [SEQ_OPCODE_W-1:0] OPC_POP   = 4'd5;
  localparam logic [SEQ_OPCODE_W-1:0] OPC_JMP   = 4'd6;
  localparam logic [SEQ_OPCODE_W-1:0] OPC_JZ    = 4'd7;
  localparam logic [SEQ_OPCODE_W-1:0] OPC_HALT  = 4'd8;

  typedef enum logic [3:0] {
    ST_RST,
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM_RD,
    ST_WB,
    ST_MEM_WR,
    ST_PUSH,
    ST_POP,
    ST_SETPC,
    ST_HALT,
    ST_TRAP
  } seqStateT;

  // Moore decode: the operation code is a pure function of the state.
  function automatic operT operOf(input seqStateT s);
    operT op;
    op = OPER_HALT;
    unique case (s)
      ST_RST:    op = OPER_RESET;
      ST_FETCH:  op = OPER_READ_INST;
      ST_DECODE: op = OPER_READ_REGS;
      ST_EXEC:   op = OPER_ENABLE_ALU_AND_RUN;
      ST_MEM_RD: op = OPER_READ_MEM;
      ST_WB:     op = OPER_WRITE_REG;
      ST_MEM_WR: op = OPER_WRITE_MEM;
      ST_PUSH:   op = OPER_PUSH_TO_STACK;
      ST_POP:    op = OPER_POP_FROM_STACK;
      ST_SETPC:  op = OPER_SET_PC;
      default:   op = OPER_HALT;
    endcase
    return op;
  endfunction

  // States whose length is set by the memory timer.
  function automatic logic isMemState(input seqStateT s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) ||
           (s == ST_MEM_WR) || (s == ST_PUSH) ||
           (s == ST_POP);
  endfunction

endpackage

// File: rtl/operation_sequencer_seq_mem_timer.sv
// Memory-step timer: fixed latency down-counter, or ready handshake
// when SEQ_MEM_WAIT_EN is defined. Emits memDone on the last cycle.
module seq_mem_timer #(
  parameter int MEM_LATENCY = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic memActive,
`ifdef SEQ_MEM_WAIT_EN
  input  logic memReady,
`endif
  output logic memDone
);

`ifdef SEQ_MEM_WAIT_EN

  // Step ends on the first ready cycle, inclusive.
  assign memDone = memActive & memReady;

`else

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  logic [CW-1:0] cnt;

  assign memDone = memActive && (cnt == '0);

  // Preload while idle or finishing, so every step entry starts full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!memActive || memDone) begin
      cnt <= CW'(MEM_LATENCY - 1);
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

`endif

endmodule

// File: rtl/operation_sequencer.sv
// Control-unit FSM walking instructions through fetch/decode/execute.
// Optional SEQ_MEM_WAIT_EN: memory steps wait on i_mem_ready.
module operation_sequencer
  import operation_sequencer_pkg::*;
#(
  parameter int OPCODE_W    = 4,
  parameter int MEM_LATENCY = 2,
  parameter int STACK_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_run,
  input  logic [OPCODE_W-1:0]                  i_opcode,
  input  logic                                 i_zero,
`ifdef SEQ_MEM_WAIT_EN
  input  logic                                 i_mem_ready,
`endif
  output logic [OPERATION_CODE_LENGTH-1:0]     o_operation,
  output logic                                 o_ir_load,
  output logic                                 o_pc_inc,
  output logic                                 o_pc_load,
  output logic [$clog2(STACK_DEPTH+1)-1:0]     o_sp,
  output logic                                 o_halted,
  output logic                                 o_trap
);

  localparam int SPW = $clog2(STACK_DEPTH + 1);

  seqStateT            state;
  seqStateT            nextState;
  seqStateT            doneTarget;
  logic [OPCODE_W-1:0] opcodeReg;
  logic [SPW-1:0]      sp;
  logic                memActive;
  logic                memDone;
  logic                lastFetch;

  assign memActive = isMemState(state);
  assign lastFetch = (state == ST_FETCH) && memDone;
  assign o_ir_load = lastFetch;
  assign o_pc_inc  = lastFetch;
  assign o_sp      = sp;

  seq_mem_timer #(
    .MEM_LATENCY (MEM_LATENCY)
  ) uTimer (
    .clk       (clk),
    .rst_n     (rst_n),
    .memActive (memActive),
`ifdef SEQ_MEM_WAIT_EN
    .memReady  (i_mem_ready),
`endif
    .memDone   (memDone)
  );

  // A finished instruction parks in IDLE once i_run has dropped.
  always_comb begin
    doneTarget = i_run ? ST_FETCH : ST_IDLE;
  end

  // Next-state: dispatch in DECODE, memory steps wait on memDone.
  always_comb begin
    nextState = state;
    unique case (state)
      ST_RST:   nextState = ST_IDLE;
      ST_IDLE:  nextState = i_run ? ST_FETCH : ST_IDLE;
      ST_FETCH: nextState = memDone ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        unique case (opcodeReg)
          OPCODE_W'(OPC_NOP):   nextState = doneTarget;
          OPCODE_W'(OPC_ALU):   nextState = ST_EXEC;
          OPCODE_W'(OPC_LOAD):  nextState = ST_MEM_RD;
          OPCODE_W'(OPC_STORE): nextState = ST_MEM_WR;
          OPCODE_W'(OPC_PUSH):
            nextState = (sp < SPW'(STACK_DEPTH)) ? ST_PUSH : ST_TRAP;
          OPCODE_W'(OPC_POP):
            nextState = (sp != '0) ? ST_POP : ST_TRAP;
          OPCODE_W'(OPC_JMP):   nextState = ST_SETPC;
          OPCODE_W'(OPC_JZ):
            nextState = i_zero ? ST_SETPC : doneTarget;
          OPCODE_W'(OPC_HALT):  nextState = ST_HALT;
          default:              nextState = ST_TRAP;
        endcase
      end
      ST_EXEC:   nextState = ST_WB;
      ST_MEM_RD: nextState = memDone ? ST_WB : ST_MEM_RD;
      ST_WB:     nextState = doneTarget;
      ST_MEM_WR: nextState = memDone ? doneTarget : ST_MEM_WR;
      ST_PUSH:   nextState = memDone ? doneTarget : ST_PUSH;
      ST_POP:    nextState = memDone ? doneTarget : ST_POP;
      ST_SETPC:  nextState = doneTarget;
      ST_HALT:   nextState = ST_HALT;
      ST_TRAP:   nextState = ST_TRAP;
      default:   nextState = ST_RST;
    endcase
  end

  // State, opcode latch, stack pointer and registered Moore outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RST;
      opcodeReg   <= '0;
      sp          <= '0;
      o_operation <= OPER_RESET;
      o_pc_load   <= 1'b0;
      o_halted    <= 1'b0;
      o_trap      <= 1'b0;
    end else begin
      state       <= nextState;
      o_operation <= operOf(nextState);
      o_pc_load   <= (nextState == ST_SETPC);
      o_halted    <= (nextState == ST_HALT) ||
                     (nextState == ST_TRAP);
      o_trap      <= (nextState == ST_TRAP);
      if (lastFetch) begin
        opcodeReg <= i_opcode;
      end
      if ((state == ST_PUSH) && memDone) begin
        sp <= sp + SPW'(1);
      end else if ((state == ST_POP) && memDone) begin
        sp <= sp - SPW'(1);
      end
    end
  end

endmodule

// File: tb/tb_operation_sequencer.sv
// Bench for operation_sequencer: instruction-level model expands
// small programs into per-cycle input/expected-output vectors.
module tb_operation_sequencer;
  import operation_sequencer_pkg::*;

  localparam int LAT   = 2;
  localparam int DEPTH = 4;
`ifdef SEQ_MEM_WAIT_EN
  localparam int MDUR = 1;
`else
  localparam int MDUR = LAT;
`endif

  typedef struct {
    logic       run;
    logic [3:0] opc;
    logic       zero;
    logic       rdy;
    operT       op;
    logic       ir;
    logic       pcl;
    logic [2:0] sp;
    logic       halted;
    logic       trap;
  } vecT;

  typedef struct {
    logic [3:0] opc;
    logic       zero;
    logic       run;
    int         stall;
  } instrT;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic [3:0] opcode;
  logic       zero;
  logic       memReady;
  operT       operation;
  logic       irLoad;
  logic       pcInc;
  logic       pcLoad;
  logic [2:0] sp;
  logic       halted;
  logic       trap;

  vecT   seq[$];
  instrT prog[$];
  int    mSp;
  bit    mHalt;
  bit    mTrap;
  int    nVec;
  int    nMiss;

  operation_sequencer #(
    .OPCODE_W    (4),
    .MEM_LATENCY (LAT),
    .STACK_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_run       (run),
    .i_opcode    (opcode),
    .i_zero      (zero),
`ifdef SEQ_MEM_WAIT_EN
    .i_mem_ready (memReady),
`endif
    .o_operation (operation),
    .o_ir_load   (irLoad),
    .o_pc_inc    (pcInc),
    .o_pc_load   (pcLoad),
    .o_sp        (sp),
    .o_halted    (halted),
    .o_trap      (trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic emit(input logic r, input logic [3:0] o,
                      input logic z, input logic rdy,
                      input operT op, input logic ir,
                      input logic pcl);
    vecT v;
    v.run = r; v.opc = o; v.zero = z; v.rdy = rdy;
    v.op = op; v.ir = ir; v.pcl = pcl;
    v.sp = 3'(mSp); v.halted = mHalt; v.trap = mTrap;
    seq.push_back(v);
  endtask

  task automatic addInstr(input logic [3:0] o, input logic z,
                          input logic r, input int stall);
    instrT t;
    t.opc = o; t.zero = z; t.run = r; t.stall = stall;
    prog.push_back(t);
  endtask

  // Expand prog into cycles: RST, IDLE, then each instruction's steps.
  task automatic build();
    logic r;
    logic [3:0] o;
    logic z;
    seq.delete();
    mSp = 0; mHalt = 0; mTrap = 0;
    emit(1, 0, 0, 1, OPER_RESET, 0, 0);
    emit(1, 0, 0, 1, OPER_HALT, 0, 0);
    for (int i = 0; i < prog.size(); i++) begin
      if (mHalt) break;
      r = prog[i].run; o = prog[i].opc; z = prog[i].zero;
      for (int j = 0; j < MDUR; j++)
        emit(r, o, z, 1, OPER_READ_INST, j == MDUR - 1, 0);
      emit(r, o, z, 1, OPER_READ_REGS, 0, 0);
      case (o)
        OPC_NOP: ;
        OPC_ALU: begin
          emit(r, o, z, 1, OPER_ENABLE_ALU_AND_RUN, 0, 0);
          emit(r, o, z, 1, OPER_WRITE_REG, 0, 0);
        end
        OPC_LOAD: begin
          for (int s = 0; s < prog[i].stall; s++)
            emit(r, o, z, 0, OPER_READ_MEM, 0, 0);
          for (int j = 0; j < MDUR; j++)
            emit(r, o, z, 1, OPER_READ_MEM, 0, 0);
          emit(r, o, z, 1, OPER_WRITE_REG, 0, 0);
        end
        OPC_STORE:
          for (int j = 0; j < MDUR; j++)
            emit(r, o, z, 1, OPER_WRITE_MEM, 0, 0);
        OPC_PUSH:
          if (mSp < DEPTH) begin
            for (int j = 0; j < MDUR; j++)
              emit(r, o, z, 1, OPER_PUSH_TO_STACK, 0, 0);
            mSp++;
          end else begin
            mHalt = 1; mTrap = 1;
          end
        OPC_POP:
          if (mSp > 0) begin
            for (int j = 0; j < MDUR; j++)
              emit(r, o, z, 1, OPER_POP_FROM_STACK, 0, 0);
            mSp--;
          end else begin
            mHalt = 1; mTrap = 1;
          end
        OPC_JMP: emit(r, o, z, 1, OPER_SET_PC, 0, 1);
        OPC_JZ:  if (z) emit(r, o, z, 1, OPER_SET_PC, 0, 1);
        OPC_HALT: mHalt = 1;
        default: begin
          mHalt = 1; mTrap = 1;
        end
      endcase
      if (!mHalt && !r) emit(1, 0, 0, 1, OPER_HALT, 0, 0);
    end
    if (mHalt)
      for (int k = 0; k < 4; k++)
        emit(logic'(k % 2), 0, 0, 1, OPER_HALT, 0, 0);
  endtask

  task automatic applyCheck(input int k, input string name);
    run = seq[k].run; opcode = seq[k].opc;
    zero = seq[k].zero; memReady = seq[k].rdy;
    #1;
    nVec++;
    if (operation !== seq[k].op || irLoad !== seq[k].ir ||
        pcInc !== seq[k].ir || pcLoad !== seq[k].pcl ||
        sp !== seq[k].sp || halted !== seq[k].halted ||
        trap !== seq[k].trap) begin
      nMiss++;
      $display("FAIL %s cyc%0d: got op=%0d ir=%b pci=%b pcl=%b sp=%0d hlt=%b trp=%b want op=%0d ir=%b pcl=%b sp=%0d hlt=%b trp=%b",
               name, k, operation, irLoad, pcInc, pcLoad, sp,
               halted, trap, seq[k].op, seq[k].ir, seq[k].pcl,
               seq[k].sp, seq[k].halted, seq[k].trap);
    end
  endtask

  task automatic runSeq(input int n, input string name);
    for (int k = 0; k < n && k < seq.size(); k++) begin
      applyCheck(k, name);
      @(negedge clk);
    end
  endtask

  task automatic checkReset(input string name);
    nVec++;
    if (operation !== OPER_RESET || sp !== 3'd0 || trap !== 1'b0 ||
        halted !== 1'b0 || irLoad !== 1'b0 || pcLoad !== 1'b0) begin
      nMiss++;
      $display("FAIL %s: got op=%0d sp=%0d trp=%b hlt=%b ir=%b pcl=%b want op=0 sp=0 all flags 0",
               name, operation, sp, trap, halted, irLoad, pcLoad);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0; run = 1'b0;
    #1;
    checkReset("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pin(input string name, input int got, input int want);
    nVec++;
    if (got != want) begin
      nMiss++;
      $display("FAIL pin %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic runProg(input string name);
    build();
    doReset();
    runSeq(seq.size(), name);
  endtask

  int   cnt;
  int   idx;
  operT aluPin[8];

  initial begin
    rst_n = 1'b0; run = 1'b0; opcode = '0; zero = 1'b0;
    memReady = 1'b1; nVec = 0; nMiss = 0;

    // Reset, then release with run low: RESET once, HALT held.
    prog.delete(); seq.delete();
    mSp = 0; mHalt = 0; mTrap = 0;
    emit(0, 0, 0, 1, OPER_RESET, 0, 0);
    for (int k = 0; k < 3; k++) emit(0, 0, 0, 1, OPER_HALT, 0, 0);
    doReset();
    runSeq(seq.size(), "idle");

    // ALU instruction then HALT.
    prog.delete();
    addInstr(OPC_ALU, 0, 1, 0);
    addInstr(OPC_HALT, 0, 1, 0);
    build();
`ifndef SEQ_MEM_WAIT_EN
    aluPin = '{OPER_RESET, OPER_HALT, OPER_READ_INST,
               OPER_READ_INST, OPER_READ_REGS,
               OPER_ENABLE_ALU_AND_RUN, OPER_WRITE_REG,
               OPER_READ_INST};
    for (int k = 0; k < 8; k++)
      pin("alu_op", int'(seq[k].op), int'(aluPin[k]));
    pin("alu_ir2", int'(seq[3].ir), 1);
    pin("alu_ir1", int'(seq[2].ir), 0);
`endif
    runProg("alu");

    // Four pushes fill the stack, the fifth traps with sp held.
    prog.delete();
    for (int i = 0; i < 5; i++) addInstr(OPC_PUSH, 0, 1, 0);
    build();
    pin("ovf_sp", int'(seq[seq.size()-1].sp), 4);
    pin("ovf_trap", int'(seq[seq.size()-1].trap), 1);
    runProg("overflow");

    // Pop on empty stack traps.
    prog.delete();
    addInstr(OPC_POP, 0, 1, 0);
    build();
    pin("unf_trap", int'(seq[seq.size()-1].trap), 1);
    runProg("underflow");

    // Underflow after the stack has been used.
    prog.delete();
    addInstr(OPC_PUSH, 0, 1, 0);
    addInstr(OPC_PUSH, 0, 1, 0);
    addInstr(OPC_POP, 0, 1, 0);
    addInstr(OPC_POP, 0, 1, 0);
    addInstr(OPC_POP, 0, 1, 0);
    runProg("pushpop");

    // Illegal opcode traps.
    prog.delete();
    addInstr(4'hC, 0, 1, 0);
    runProg("illegal");

    // Branches, memory ops, and a run drop mid-instruction.
    prog.delete();
    addInstr(OPC_JZ, 0, 1, 0);
    addInstr(OPC_JZ, 1, 1, 0);
    addInstr(OPC_JMP, 0, 1, 0);
    addInstr(OPC_NOP, 0, 1, 0);
    addInstr(OPC_STORE, 0, 1, 0);
    addInstr(OPC_LOAD, 0, 1, 0);
    addInstr(OPC_ALU, 0, 0, 0);
    addInstr(OPC_NOP, 0, 1, 0);
    addInstr(OPC_HALT, 0, 1, 0);
    build();
    cnt = 0;
    foreach (seq[k]) if (seq[k].op == OPER_SET_PC) cnt++;
    pin("setpc_cycles", cnt, 2);
    runProg("mixed");

`ifdef SEQ_MEM_WAIT_EN
    // LOAD with ready low 5 cycles: READ_MEM held 6 cycles.
    prog.delete();
    addInstr(OPC_LOAD, 0, 1, 5);
    addInstr(OPC_HALT, 0, 1, 0);
    build();
    cnt = 0;
    foreach (seq[k]) if (seq[k].op == OPER_READ_MEM) cnt++;
    pin("wait_rdmem", cnt, 6);
    runProg("wait");
`endif

    // Async reset during the first READ_MEM cycle of a LOAD.
    prog.delete();
    addInstr(OPC_PUSH, 0, 1, 0);
    addInstr(OPC_LOAD, 0, 1, 0);
    addInstr(OPC_HALT, 0, 1, 0);
    build();
    idx = -1;
    foreach (seq[k]) if (idx < 0 && seq[k].op == OPER_READ_MEM) idx = k;
    pin("rd_sp", int'(seq[idx].sp), 1);
    doReset();
    runSeq(idx, "midload");
    applyCheck(idx, "midload");
    #2;
    rst_n = 1'b0;
    #1;
    checkReset("midload_rst");
    @(negedge clk);

    // Normal program after the mid-op reset: counter starts fresh.
    prog.delete();
    addInstr(OPC_LOAD, 0, 1, 0);
    addInstr(OPC_HALT, 0, 1, 0);
    runProg("postreset");

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
